// File: rtl/tetris_move_sched.sv
// tetris_move_sched
//   Arbitrates player button moves and gravity into a single valid/ready move
//   stream for the game FSM. Each button is edge-detected into a one-deep
//   pending bit. A level-dependent gravity counter sets a DOWN pending bit.
//   Granted moves are followed by a fixed cooldown before the next offer.
//
// Ports
//   clk, rst        clock and asynchronous active-high reset
//   en              game active; low forces OFF and discards all pending work
//   right, left,
//   rr, rl          synchronized button levels
//   soft_drop       selects FAST_PERIOD as the gravity period
//   level[3:0]      speed level; period = BASE_PERIOD >> level, clamped
//   move_ready      consumer accepts the offered move
//   move_valid      a move is offered
//   move[2:0]       NONE=0 DOWN=1 LEFT=2 RIGHT=3 ROR=4 ROL=5
//   grav_tick       one-cycle pulse on each gravity expiry
module tetris_move_sched #(
  parameter logic [23:0] BASE_PERIOD = 24'd12_500_000,
  parameter logic [23:0] MIN_PERIOD  = 24'd500_000,
  parameter logic [23:0] FAST_PERIOD = 24'd1_000_000,
  parameter int          COOLDOWN    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       right,
  input  logic       left,
  input  logic       rr,
  input  logic       rl,
  input  logic       soft_drop,
  input  logic [3:0] level,
  input  logic       move_ready,
  output logic       move_valid,
  output logic [2:0] move,
  output logic       grav_tick
);

  localparam logic [2:0] MV_NONE  = 3'd0;
  localparam logic [2:0] MV_DOWN  = 3'd1;
  localparam logic [2:0] MV_LEFT  = 3'd2;
  localparam logic [2:0] MV_RIGHT = 3'd3;
  localparam logic [2:0] MV_ROR   = 3'd4;
  localparam logic [2:0] MV_ROL   = 3'd5;

  localparam int CW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

  typedef enum logic [1:0] {ST_OFF, ST_IDLE, ST_OFFER, ST_COOL} state_t;

  state_t      state_reg, state_next;

  // Pending bit i belongs to move code i+1: {ROL, ROR, RIGHT, LEFT, DOWN}.
  logic [4:0]  pend_reg;
  logic [4:0]  pend_next;
  logic [3:0]  prev_reg;        // button history, same order as pend_reg[4:1]
  logic [23:0] cnt_reg;
  logic        grav_tick_reg;
  logic [2:0]  move_reg;
  logic        last_user_reg;   // previous grant was a player move
  logic [CW-1:0] cool_reg;

  logic [3:0]  btn;
  logic [3:0]  btn_edge;
  logic [23:0] shifted;
  logic [23:0] period;
  logic        active;
  logic        expire;
  logic        grant;
  logic [4:0]  set_vec;
  logic [4:0]  clr_vec;
  logic        user_any;
  logic [2:0]  user_sel;
  logic [2:0]  sel_move;
  logic        cool_done;
  logic        arb;

  assign btn      = {rl, rr, right, left};
  assign active   = en && (state_reg != ST_OFF);
  assign btn_edge = btn & ~prev_reg;

  assign shifted = BASE_PERIOD >> level;
  assign period  = soft_drop ? FAST_PERIOD
                 : ((shifted < MIN_PERIOD) ? MIN_PERIOD : shifted);
  // >= rather than == so a period shortened mid-count expires at once.
  assign expire  = active && (cnt_reg >= (period - 24'd1));

  assign grant   = (state_reg == ST_OFFER) && move_ready;
  assign set_vec = active ? {btn_edge, expire} : 5'd0;
  assign clr_vec = grant ? (5'd1 << (move_reg - 3'd1)) : 5'd0;
  // Set after clear: an edge coinciding with its own grant stays pending.
  assign pend_next = (pend_reg & ~clr_vec) | set_vec;

  assign user_any = |pend_reg[4:1];
  always_comb begin
    user_sel = MV_ROL;
    if (pend_reg[2])      user_sel = MV_RIGHT;
    else if (pend_reg[1]) user_sel = MV_LEFT;
    else if (pend_reg[3]) user_sel = MV_ROR;
  end

  // Gravity jumps ahead of player moves only right after a player grant,
  // so neither side can starve the other.
  always_comb begin
    sel_move = MV_NONE;
    if (pend_reg[0] && (last_user_reg || !user_any)) sel_move = MV_DOWN;
    else if (user_any)                                sel_move = user_sel;
  end

  assign cool_done = (cool_reg == CW'(COOLDOWN - 1));
  // The last cooldown cycle doubles as the arbitration cycle, so an offer
  // can follow COOLDOWN idle cycles after a grant with no extra bubble.
  assign arb = (state_reg == ST_IDLE) || ((state_reg == ST_COOL) && cool_done);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_OFF;
    else     state_reg <= state_next;
  end

  // FSM next state
  always_comb begin
    state_next = state_reg;
    if (!en) begin
      state_next = ST_OFF;
    end else begin
      case (state_reg)
        ST_OFF:   state_next = ST_IDLE;
        ST_IDLE:  if (sel_move != MV_NONE) state_next = ST_OFFER;
        ST_OFFER: if (move_ready) state_next = (COOLDOWN == 0) ? ST_IDLE : ST_COOL;
        ST_COOL:  if (cool_done)
                    state_next = (sel_move != MV_NONE) ? ST_OFFER : ST_IDLE;
        default:  state_next = ST_OFF;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    move_valid = (state_reg == ST_OFFER);
    move       = move_valid ? move_reg : MV_NONE;
    grav_tick  = grav_tick_reg;
  end

  // Datapath: edge history, pending bits, gravity, cooldown, offered move
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_reg      <= '0;
      pend_reg      <= '0;
      cnt_reg       <= '0;
      grav_tick_reg <= 1'b0;
      move_reg      <= MV_NONE;
      last_user_reg <= 1'b0;
      cool_reg      <= '0;
    end else if (!en) begin
      prev_reg      <= '0;
      pend_reg      <= '0;
      cnt_reg       <= '0;
      grav_tick_reg <= 1'b0;
      move_reg      <= MV_NONE;
      last_user_reg <= 1'b0;
      cool_reg      <= '0;
    end else begin
      prev_reg      <= active ? btn : 4'd0;
      pend_reg      <= pend_next;
      grav_tick_reg <= expire;
      if (!active || expire) cnt_reg <= '0;
      else                   cnt_reg <= cnt_reg + 24'd1;
      if (arb && (sel_move != MV_NONE)) move_reg <= sel_move;
      if (grant) begin
        last_user_reg <= (move_reg != MV_DOWN);
        cool_reg      <= '0;
      end else if (state_reg == ST_COOL) begin
        cool_reg      <= cool_reg + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_tetris_move_sched.sv
// Directed testbench for tetris_move_sched with a short gravity period
// (BASE=64, MIN=4, FAST=8, COOLDOWN=2). Inputs change and outputs are
// sampled on the falling clock edge.
module tb_tetris_move_sched;

  localparam logic [2:0] MV_NONE  = 3'd0;
  localparam logic [2:0] MV_DOWN  = 3'd1;
  localparam logic [2:0] MV_LEFT  = 3'd2;
  localparam logic [2:0] MV_RIGHT = 3'd3;
  localparam logic [2:0] MV_ROR   = 3'd4;
  localparam logic [2:0] MV_ROL   = 3'd5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       right = 1'b0, left = 1'b0, rr = 1'b0, rl = 1'b0;
  logic       soft_drop = 1'b0;
  logic [3:0] level = 4'd0;
  logic       move_ready = 1'b0;
  logic       move_valid;
  logic [2:0] move;
  logic       grav_tick;

  int checks = 0;
  int errors = 0;

  tetris_move_sched #(
    .BASE_PERIOD(24'd64),
    .MIN_PERIOD (24'd4),
    .FAST_PERIOD(24'd8),
    .COOLDOWN   (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .right     (right),
    .left      (left),
    .rr        (rr),
    .rl        (rl),
    .soft_drop (soft_drop),
    .level     (level),
    .move_ready(move_ready),
    .move_valid(move_valid),
    .move      (move),
    .grav_tick (grav_tick)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Drop en for a cycle to clear counter/pending state, then re-enable;
  // on return the FSM is IDLE with the gravity counter at 0.
  task automatic restart();
    en = 1'b0;
    step();
    en = 1'b1;
    step();
  endtask

  task automatic wait_offer(output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < 40) begin
      if (move_valid) begin
        ok = 1'b1;
        $display("offer move=%0d after %0d cycles at %0t", move, n, $time);
        break;
      end
      step();
      n++;
    end
  endtask

  task automatic wait_tick(input int limit, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < limit) begin
      step();
      n++;
      if (grav_tick) begin
        ok = 1'b1;
        break;
      end
    end
    $display("grav_tick wait %0d cycles found=%0d", n, ok);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b1;
    right = 1'b1;
    step(3);
    checks++; if (move_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", move_valid); end
    checks++; if (move !== MV_NONE) begin errors++; $display("FAIL reset_move: got %0d expected 0", move); end
    checks++; if (grav_tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %0b expected 0", grav_tick); end
    right = 1'b0;
    en = 1'b0;
    rst = 1'b0;
    step();
    $display("reset test done");
  endtask

  task automatic test_gravity();
    int n; bit ok;
    level = 4'd0; soft_drop = 1'b0; move_ready = 1'b1;
    restart();
    wait_tick(100, n, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL grav_first_tick: got %0b expected 1", ok); end
    step();
    checks++; if (move_valid !== 1'b1 || move !== MV_DOWN) begin errors++; $display("FAIL grav_down_offer: got valid=%0b move=%0d expected valid=1 move=1", move_valid, move); end
    checks++; if (grav_tick !== 1'b0) begin errors++; $display("FAIL grav_pulse_width: got %0b expected 0", grav_tick); end
    step();
    checks++; if (move_valid !== 1'b0) begin errors++; $display("FAIL grav_down_granted: got %0b expected 0", move_valid); end
    // two cycles already consumed since the tick
    wait_tick(100, n, ok);
    checks++; if (n !== 62) begin errors++; $display("FAIL grav_period64_a: got %0d expected 62", n); end
    wait_tick(100, n, ok);
    checks++; if (n !== 64) begin errors++; $display("FAIL grav_period64_b: got %0d expected 64", n); end
  endtask

  task automatic test_level();
    int n; bit ok;
    level = 4'd5;
    wait_tick(70, n, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL lvl5_first_tick: got %0b expected 1", ok); end
    wait_tick(20, n, ok);
    checks++; if (n !== 4) begin errors++; $display("FAIL lvl5_period_a: got %0d expected 4", n); end
    wait_tick(20, n, ok);
    checks++; if (n !== 4) begin errors++; $display("FAIL lvl5_period_b: got %0d expected 4", n); end
    level = 4'd0; soft_drop = 1'b1;
    wait_tick(20, n, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL soft_first_tick: got %0b expected 1", ok); end
    wait_tick(20, n, ok);
    checks++; if (n !== 8) begin errors++; $display("FAIL soft_period_a: got %0d expected 8", n); end
    wait_tick(20, n, ok);
    checks++; if (n !== 8) begin errors++; $display("FAIL soft_period_b: got %0d expected 8", n); end
    // Shortening the period with the count already past it expires next cycle.
    soft_drop = 1'b0;
    wait_tick(100, n, ok);
    step(20);
    level = 4'd5;
    wait_tick(5, n, ok);
    checks++; if (n !== 1 || ok !== 1'b1) begin errors++; $display("FAIL period_change_immediate: got %0d cycles found=%0b expected 1 found=1", n, ok); end
    level = 4'd0;
    step(3);
  endtask

  task automatic test_simultaneous();
    int n; bit ok;
    move_ready = 1'b1;
    restart();
    step(2);
    right = 1'b1; left = 1'b1;
    wait_offer(n, ok);
    checks++; if (ok !== 1'b1 || move !== MV_RIGHT) begin errors++; $display("FAIL simul_first_right: got move=%0d found=%0b expected 3", move, ok); end
    step();
    checks++; if (move_valid !== 1'b0) begin errors++; $display("FAIL simul_cool1: got %0b expected 0", move_valid); end
    step();
    checks++; if (move_valid !== 1'b0) begin errors++; $display("FAIL simul_cool2: got %0b expected 0", move_valid); end
    step();
    checks++; if (move_valid !== 1'b1 || move !== MV_LEFT) begin errors++; $display("FAIL simul_left_at_3: got valid=%0b move=%0d expected valid=1 move=2", move_valid, move); end
    right = 1'b0; left = 1'b0;
    step(4);
  endtask

  task automatic test_hold();
    int n; bit ok; int offers;
    move_ready = 1'b0;
    restart();
    rr = 1'b1;
    wait_offer(n, ok);
    checks++; if (ok !== 1'b1 || move !== MV_ROR) begin errors++; $display("FAIL hold_offer_ror: got move=%0d found=%0b expected 4", move, ok); end
    for (int i = 0; i < 10; i++) begin
      checks++; if (move_valid !== 1'b1 || move !== MV_ROR) begin errors++; $display("FAIL hold_stable_%0d: got valid=%0b move=%0d expected valid=1 move=4", i, move_valid, move); end
      if (i == 3) rr = 1'b0;
      if (i == 5) rr = 1'b1;   // second edge while pending is dropped
      step();
    end
    move_ready = 1'b1;
    step();
    checks++; if (move_valid !== 1'b0) begin errors++; $display("FAIL hold_grant_drop: got %0b expected 0", move_valid); end
    offers = 0;
    for (int i = 0; i < 12; i++) begin
      if (move_valid) offers++;
      step();
    end
    checks++; if (offers !== 0) begin errors++; $display("FAIL hold_single_grant: got %0d extra offers expected 0", offers); end
    rr = 1'b0;
    step();
  endtask

  task automatic test_set_wins();
    int n; bit ok;
    move_ready = 1'b0;
    restart();
    rl = 1'b1;
    wait_offer(n, ok);
    checks++; if (ok !== 1'b1 || move !== MV_ROL) begin errors++; $display("FAIL setwin_offer_rol: got move=%0d found=%0b expected 5", move, ok); end
    rl = 1'b0;
    step();
    rl = 1'b1; move_ready = 1'b1;   // edge in the grant cycle
    step(3);
    checks++; if (move_valid !== 1'b1 || move !== MV_ROL) begin errors++; $display("FAIL setwin_reoffer: got valid=%0b move=%0d expected valid=1 move=5", move_valid, move); end
    rl = 1'b0;
    step(4);
  endtask

  task automatic test_down_first();
    int n; bit ok;
    move_ready = 1'b1; level = 4'd0;
    restart();
    step(5);
    right = 1'b1;
    wait_offer(n, ok);
    checks++; if (ok !== 1'b1 || move !== MV_RIGHT) begin errors++; $display("FAIL dfirst_right: got move=%0d found=%0b expected 3", move, ok); end
    // Gravity expires and ROL rises while RIGHT is being granted.
    right = 1'b0; rl = 1'b1; level = 4'd5;
    step();
    wait_offer(n, ok);
    checks++; if (ok !== 1'b1 || move !== MV_DOWN) begin errors++; $display("FAIL dfirst_down: got move=%0d found=%0b expected 1", move, ok); end
    step();
    wait_offer(n, ok);
    checks++; if (ok !== 1'b1 || move !== MV_ROL) begin errors++; $display("FAIL dfirst_then_rol: got move=%0d found=%0b expected 5", move, ok); end
    rl = 1'b0; level = 4'd0;
    step(4);
  endtask

  task automatic test_rst_offer();
    int n; bit ok;
    move_ready = 1'b0;
    restart();
    rr = 1'b1;
    wait_offer(n, ok);
    checks++; if (ok !== 1'b1 || move !== MV_ROR) begin errors++; $display("FAIL rstoff_offer: got move=%0d found=%0b expected 4", move, ok); end
    #2 rst = 1'b1;
    #1;
    checks++; if (move_valid !== 1'b0 || move !== MV_NONE) begin errors++; $display("FAIL rstoff_async_drop: got valid=%0b move=%0d expected 0/0", move_valid, move); end
    rr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step(3);
    checks++; if (move_valid !== 1'b0) begin errors++; $display("FAIL rstoff_no_grant: got %0b expected 0", move_valid); end
  endtask

  task automatic test_en_drop();
    int n; bit ok; int offers;
    move_ready = 1'b0;
    restart();
    rl = 1'b1;
    wait_offer(n, ok);
    checks++; if (ok !== 1'b1 || move !== MV_ROL) begin errors++; $display("FAIL endrop_offer: got move=%0d found=%0b expected 5", move, ok); end
    left = 1'b1;
    step();
    en = 1'b0;
    step();
    checks++; if (move_valid !== 1'b0) begin errors++; $display("FAIL endrop_withdraw: got %0b expected 0", move_valid); end
    rl = 1'b0; left = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++; if (move_valid !== 1'b0) begin errors++; $display("FAIL endrop_rst_valid: got %0b expected 0", move_valid); end
    @(negedge clk);
    rst = 1'b0;
    en = 1'b1; move_ready = 1'b1;
    offers = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (move_valid) offers++;
    end
    checks++; if (offers !== 0) begin errors++; $display("FAIL endrop_no_reissue: got %0d offers expected 0", offers); end
  endtask

  initial begin
    test_reset();
    test_gravity();
    test_level();
    test_simultaneous();
    test_hold();
    test_set_wins();
    test_down_first();
    test_rst_offer();
    test_en_drop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
